// File: rtl/mem_pkg.sv
// Shared types and constants for the unified memory and its lane initiators.
package mem_pkg;

  localparam int MEM_WIDTH   = 32;
  localparam int MEM_RAMSIZE = 512;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef struct packed {
    mem_op_t                we;
    logic [MEM_WIDTH-1:0]   addr;
    logic [MEM_WIDTH-1:0]   wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } initiator_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; shared by all memory lanes.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Payload storage; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read/write pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

endmodule

// File: rtl/mem_lane_initiator.sv
// One lane initiator: buffers load/store requests, performs a one-cycle lane
// access per request and returns in-order responses.
module mem_lane_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH   = MEM_WIDTH,
  parameter int RAMSIZE = MEM_RAMSIZE,
  parameter int DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef struct packed {
    mem_op_t          we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } lane_req_t;

  localparam int                REQ_W     = $bits(lane_req_t);
  localparam logic [WIDTH-1:0]  RAMSIZE_W = WIDTH'(RAMSIZE);

  initiator_state_t state_r;
  initiator_state_t state_next_s;
  lane_req_t        tail_s;
  lane_req_t        head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             in_range_s;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_err_r;

  assign tail_s     = '{we: mem_op_t'(req_we), addr: req_addr, wdata: req_wdata};
  assign req_ready  = !full_s;
  assign push_s     = req_valid && !full_s;
  assign pop_s      = (state_r == ACCESS);
  assign in_range_s = (head_s.addr < RAMSIZE_W);
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;

  sync_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (tail_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; a same-cycle push counts when leaving RESP.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_next_s = ACCESS;
        else          state_next_s = IDLE;
      end
      ACCESS: state_next_s = RESP;
      RESP: begin
        if (rsp_ready && (!empty_s || push_s)) state_next_s = ACCESS;
        else if (rsp_ready)                   state_next_s = IDLE;
        else                                  state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Lane drive and response-valid decode; rst gates the write enable directly.
  always_comb begin
    mem_a     = {WIDTH{1'b0}};
    mem_wd    = {WIDTH{1'b0}};
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_r)
      ACCESS: begin
        mem_a  = head_s.addr;
        mem_wd = head_s.wdata;
        mem_we = (head_s.we == MEM_STORE) && in_range_s && !rst;
      end
      RESP:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Response capture at the end of the access cycle, held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_err_r  <= 1'b0;
    end else if (state_r == ACCESS) begin
      rsp_data_r <= ((head_s.we == MEM_LOAD) && in_range_s) ? mem_rd : {WIDTH{1'b0}};
      rsp_err_r  <= !in_range_s;
    end
  end

endmodule

// File: tb/tb_mem_lane_initiator.sv
// Self-checking bench: lane memory model plus an in-order request/response reference.
module tb_mem_lane_initiator;

  localparam int RAMSIZE = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  mem_lane_initiator #(.WIDTH(32), .RAMSIZE(RAMSIZE), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Lane memory: combinational read, write on posedge.
  logic [31:0] init_mem [RAMSIZE];
  logic [31:0] env_mem  [RAMSIZE];
  logic        init_en = 1'b0;
  assign mem_rd = (mem_a < 32'd512) ? env_mem[mem_a[8:0]] : 32'd0;
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < RAMSIZE; i++) env_mem[i] <= init_mem[i];
    end else if (mem_we && (mem_a < 32'd512)) begin
      env_mem[mem_a[8:0]] <= mem_wd;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tb_req_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } tb_rsp_t;

  logic [31:0] ref_mem [RAMSIZE];
  tb_req_t     req_q[$];
  tb_rsp_t     rsp_log[$];
  int          rsp_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_edge = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 32'd0;
  bit          stall_v = 1'b0;
  logic [31:0] stall_d = 32'd0;
  logic        stall_e = 1'b0;

  // One clock: score handshakes seen with current inputs, then advance.
  task automatic step();
    tb_req_t r;
    logic [31:0] exp_d;
    logic        exp_e;
    if (rst) begin
      @(posedge clk);
      cyc++;
      req_q.delete();
      stall_v = 1'b0;
      #1;
      return;
    end
    if (stall_v) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== stall_d || rsp_err !== stall_e) begin
        failures++;
        $display("FAIL rsp_hold got v=%b d=%h e=%b exp v=1 d=%h e=%b", rsp_valid, rsp_data, rsp_err, stall_d, stall_e);
      end
    end
    if (mem_we === 1'b1) begin
      we_cnt++;
      we_addr = mem_a;
    end
    if (rsp_valid === 1'b1 && rsp_ready) begin
      checks++;
      if (req_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got d=%h e=%b exp no response", rsp_data, rsp_err);
      end else begin
        r = req_q.pop_front();
        if (r.addr >= 32'd512) begin
          exp_e = 1'b1; exp_d = 32'd0;
        end else if (r.we) begin
          exp_e = 1'b0; exp_d = 32'd0;
          ref_mem[r.addr[8:0]] = r.wdata;
        end else begin
          exp_e = 1'b0; exp_d = ref_mem[r.addr[8:0]];
        end
        if (rsp_data !== exp_d || rsp_err !== exp_e) begin
          failures++;
          $display("FAIL rsp_value addr=%h we=%b got d=%h e=%b exp d=%h e=%b", r.addr, r.we, rsp_data, rsp_err, exp_d, exp_e);
        end
      end
      rsp_log.push_back('{data: rsp_data, err: rsp_err});
      rsp_cyc.push_back(cyc);
    end
    stall_v = (rsp_valid === 1'b1) && !rsp_ready;
    stall_d = rsp_data;
    stall_e = rsp_err;
    if (req_valid && req_ready === 1'b1) begin
      req_q.push_back('{we: req_we, addr: req_addr, wdata: req_wdata});
      acc_edge = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd, input bit rnd_ready);
    bit acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      acc = (req_ready === 1'b1);
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout got req_ready=%b exp accept within 100 cycles", req_ready);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (req_q.size() != 0 || rsp_valid === 1'b1); i++) step();
    checks++;
    if (req_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d exp 0", req_q.size());
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom_range(0, 511); req_wdata = $urandom;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got rsp_valid=%b mem_we=%b exp 0 0", rsp_valid, mem_we);
      end
      step();
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b v=%b d=%h e=%b exp 1 0 0 0", req_ready, rsp_valid, rsp_data, rsp_err);
    end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_rsp got %0d valid cycles exp 0", seen);
    end
  endtask

  task automatic test_store_load();
    int first_edge;
    rsp_ready = 1'b1; we_cnt = 0; rsp_log.delete(); rsp_cyc.delete();
    send(1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
    first_edge = acc_edge;
    send(1'b0, 32'd5, 32'd0, 1'b0);
    drain();
    checks++;
    if (we_cnt != 1 || we_addr !== 32'd5) begin
      failures++;
      $display("FAIL store_we got cnt=%0d addr=%h exp cnt=1 addr=5", we_cnt, we_addr);
    end
    checks++;
    if (rsp_log.size() != 2 || rsp_log[1].data !== 32'hDEADBEEF || rsp_log[1].err !== 1'b0) begin
      failures++;
      $display("FAIL load_after_store got n=%0d exp n=2 d=deadbeef e=0", rsp_log.size());
    end
    checks++;
    if (rsp_cyc.size() < 1 || rsp_cyc[0] - first_edge != 3) begin
      failures++;
      $display("FAIL latency got %0d exp 3", (rsp_cyc.size() > 0) ? rsp_cyc[0] - first_edge : -1);
    end
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1; we_cnt = 0; rsp_log.delete();
    send(1'b1, 32'd512, $urandom, 1'b0);
    send(1'b0, 32'd0, 32'd0, 1'b0);
    drain();
    checks++;
    if (we_cnt != 0) begin
      failures++;
      $display("FAIL oor_we got %0d pulses exp 0", we_cnt);
    end
    checks++;
    if (rsp_log.size() != 2 || rsp_log[0].err !== 1'b1 || rsp_log[0].data !== 32'd0 ||
        rsp_log[1].err !== 1'b0 || rsp_log[1].data !== init_mem[0]) begin
      failures++;
      $display("FAIL oor_rsp got n=%0d exp err store then word0=%h", rsp_log.size(), init_mem[0]);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; rsp_log.delete();
    for (int a = 1; a <= 3; a++) send(1'b0, 32'(a), 32'd0, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd4;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_full got ready=%b v=%b exp 0 1", req_ready, rsp_valid);
      end
      step();
    end
    rsp_ready = 1'b1;
    send(1'b0, 32'd4, 32'd0, 1'b0);
    drain();
    checks++;
    if (rsp_log.size() != 4) begin
      failures++;
      $display("FAIL bp_count got %0d exp 4", rsp_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rsp_log[i].data !== init_mem[i+1]) begin
          failures++;
          $display("FAIL bp_order idx=%0d got %h exp %h", i, rsp_log[i].data, init_mem[i+1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    rsp_ready = 1'b1; rsp_log.delete();
    send(1'b1, 32'd7, 32'h12345678, 1'b0);
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 32'd7) begin
      failures++;
      $display("FAIL mid_access got we=%b a=%h exp 1 7", mem_we, mem_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_we got %b exp 0", mem_we);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_dropped got %0d valid cycles exp 0", seen);
    end
    rsp_log.delete();
    send(1'b0, 32'd7, 32'd0, 1'b0);
    drain();
    checks++;
    if (rsp_log.size() != 1 || rsp_log[0].data !== init_mem[7]) begin
      failures++;
      $display("FAIL mid_orig got n=%0d exp word7=%h", rsp_log.size(), init_mem[7]);
    end
  endtask

  task automatic test_stream();
    rsp_ready = 1'b1; rsp_log.delete(); rsp_cyc.delete();
    for (int i = 0; i < 8; i++) send(1'b0, 32'($urandom_range(8, 511)), 32'd0, 1'b0);
    drain();
    checks++;
    if (rsp_cyc.size() != 8) begin
      failures++;
      $display("FAIL stream_count got %0d exp 8", rsp_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (rsp_cyc[i] - rsp_cyc[i-1] != 2) begin
          failures++;
          $display("FAIL stream_gap idx=%0d got %0d exp 2", i, rsp_cyc[i] - rsp_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(510, 520));
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 15));
      endcase
      send(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < RAMSIZE; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_en = 1'b1;
    @(posedge clk);
    #1;
    init_en = 1'b0;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lane_initiator.md
Name: mem_lane_initiator

Overview:
Initiator side of one lane of the seven-lane unified memory. It accepts load/store requests from a pipeline stage over a valid/ready handshake and buffers them in a small FIFO. It drives the memory lane's address, write-data and write-enable signals and captures the lane's combinational read data. Results return in request order over a valid/ready response channel. The top level instantiates up to seven of these, one per lane slice of the memory's a/wd/we/rd buses.

Parameters:
WIDTH, 32, data and address width; matches the memory lane slice.
RAMSIZE, 512, number of words in the lane; addresses >= RAMSIZE are out of range.
DEPTH, 2, request FIFO entries (power of two, >= 2).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  FIFO can accept; equals !full.
req_we  in  1  1 = store, 0 = load.
req_addr  in  WIDTH  word address.
req_wdata  in  WIDTH  store data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  WIDTH  load data; 0 for stores and errors.
rsp_err  out  1  request address was out of range.
mem_a  out  WIDTH  lane address to memory.
mem_wd  out  WIDTH  lane write data to memory.
mem_we  out  1  lane write enable to memory.
mem_rd  in  WIDTH  lane read data from memory (combinational from mem_a).

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; state = IDLE.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0.
  - mem_we forced 0 during any cycle rst = 1; this gating is combinational.
- Push: req_valid && req_ready at a posedge writes {we, addr, wdata} to the FIFO tail.
  - No bypass: a full FIFO stays not-ready even if a pop occurs in the same cycle.
- FSM, three states:
  - IDLE: if FIFO non-empty -> ACCESS, else stay.
  - ACCESS (exactly one cycle): mem_a = head.addr; mem_wd = head.wdata; mem_we = head.we && in_range && !rst.
    - At the posedge: rsp_data <= (load && in_range) ? mem_rd : 0; rsp_err <= !in_range; pop head; -> RESP.
  - RESP: rsp_valid = 1; rsp_data and rsp_err held stable until handshake.
    - On rsp_ready: if FIFO non-empty (after any same-cycle push) -> ACCESS, else -> IDLE.
- Outside ACCESS: mem_a = 0, mem_wd = 0, mem_we = 0.
- in_range = (head.addr < RAMSIZE), as an unsigned WIDTH-bit compare. Out-of-range stores never assert mem_we.
- Latency: request accepted at edge N (idle, empty FIFO):
  - cycle N+1 IDLE; cycle N+2 ACCESS; rsp_valid high in cycle N+3.
  - With rsp_ready held high, sustained throughput is one request per 2 cycles.
- Ordering: strictly in order. A store commits at the posedge ending its ACCESS cycle, so a later load to the same address returns the new value.
- Backpressure: while RESP is stalled the FIFO keeps accepting until full, then req_ready = 0.
- FIFO pointers: log2(DEPTH)+1 bits. Full when the index bits are equal and the MSBs differ; wrap-around is natural modulo.
- Reset mid-operation: a request in flight is dropped and no response is produced. A store in ACCESS during the rst cycle does not write.

Decomposition:
- Shared package mem_pkg:
  - mem_op_t (MEM_LOAD, MEM_STORE).
  - mem_req_t packed struct {we, addr, wdata}.
  - initiator_state_t enum (IDLE, ACCESS, RESP).
  - The WIDTH and RAMSIZE defaults as constants shared with the unified memory.
- One sub-module: sync_fifo (parameterised by payload width and DEPTH; push/pop/full/empty, synchronous rst). It is reusable by other lanes.

Test Plan:
1. Assert rst 2 cycles with req_valid = 1 -> rsp_valid = 0, mem_we = 0, req_ready = 1 after release, and no response appears.
2. Store 0xDEADBEEF to addr 5, then load addr 5 with rsp_ready = 1 -> mem_we high exactly 1 cycle with mem_a = 5; load rsp_data = 0xDEADBEEF, rsp_err = 0; first rsp_valid 3 cycles after the request handshake.
3. Store to addr 512 (RAMSIZE) -> mem_we stays 0, rsp_err = 1, rsp_data = 0; a following load to addr 0 returns preloaded mem1 word 0 unchanged.
4. Hold rsp_ready = 0; issue 4 back-to-back loads to addrs 1,2,3,4 -> req_ready drops after the FIFO fills. Release rsp_ready -> four responses in order 1,2,3,4, each held stable while stalled.
5. Issue a store of 0x12345678 to addr 7 and assert rst during its ACCESS cycle -> mem_we = 0 that cycle; a later load of addr 7 returns the original contents.
6. Stream 8 loads with rsp_ready = 1 -> one response every 2 cycles, with no drops or duplicates across FIFO pointer wrap-around.
